// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, ciphertext ten cycles after accept.
// Round keys arrive combinationally from the key-expansion stage and are selected by the round counter.
module aes128_encrypt_iter (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         in_ready,
   input  logic [127:0] in,
   input  logic [127:0] key0,
   input  logic [127:0] key1,
   input  logic [127:0] key2,
   input  logic [127:0] key3,
   input  logic [127:0] key4,
   input  logic [127:0] key5,
   input  logic [127:0] key6,
   input  logic [127:0] key7,
   input  logic [127:0] key8,
   input  logic [127:0] key9,
   input  logic [127:0] key10,
   output logic [127:0] out,
   output logic         out_valid
);

   // FIPS-197 S-box; element 0 sits in the most significant byte of the literal.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t         fsm;
   fsm_t         fsm_next;
   logic [3:0]   rnd;
   logic [127:0] state;
   logic [127:0] round_key;
   logic [127:0] shifted;
   logic [127:0] mixed;
   logic         accept;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte i of the block is row i%4, column i/4; row r rotates left by r columns.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127-8*(row+4*c) -: 8] = SBOX[s[127-8*(row+4*((c+row)%4)) -: 8]];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = xtime(a1 ^ a2) ^ a0 ^ a2 ^ a3;
         r[111-32*c -: 8] = xtime(a2 ^ a3) ^ a0 ^ a1 ^ a3;
         r[103-32*c -: 8] = xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2;
      end
      return r;
   endfunction

   always_comb begin
      round_key = key0;
      case (rnd)
         4'd1:    round_key = key1;
         4'd2:    round_key = key2;
         4'd3:    round_key = key3;
         4'd4:    round_key = key4;
         4'd5:    round_key = key5;
         4'd6:    round_key = key6;
         4'd7:    round_key = key7;
         4'd8:    round_key = key8;
         4'd9:    round_key = key9;
         4'd10:   round_key = key10;
         default: round_key = key0;
      endcase
   end

   assign shifted = sub_shift(state);
   assign mixed   = mix_columns(shifted);
   assign accept  = start && in_ready;

   always_ff @(posedge clk) begin
      if (rst) fsm <= IDLE;
      else     fsm <= fsm_next;
   end

   always_comb begin
      fsm_next = fsm;
      case (fsm)
         IDLE:    if (start) fsm_next = RUN;
         RUN:     if (rnd >= 4'd10) fsm_next = DONE;
         DONE:    fsm_next = start ? RUN : IDLE;
         default: fsm_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (fsm != RUN);
      out_valid = (fsm == DONE);
   end

   // The last round skips MixColumns and lands in the output register, leaving state untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= '0;
         out   <= '0;
         rnd   <= '0;
      end else if (accept) begin
         state <= in ^ key0;
         rnd   <= 4'd1;
      end else if (fsm == RUN) begin
         if (rnd >= 4'd10) begin
            out <= shifted ^ round_key;
         end else begin
            state <= mixed ^ round_key;
            rnd   <= rnd + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter: FIPS vectors, back-to-back, abort and random regression
// against a software AES-128 model built from GF(2^8) arithmetic.
module tb_aes128_encrypt_iter;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk;
   logic         rst;
   logic         start;
   logic         in_ready;
   logic [127:0] pt_in;
   logic [127:0] rk [0:10];
   logic [127:0] out;
   logic         out_valid;

   logic [7:0]   sbox_m [0:255];
   int           tests_run;
   int           tests_failed;
   int           valid_count;
   int           accept_count;

   aes128_encrypt_iter dut (
      .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .in(pt_in),
      .key0(rk[0]), .key1(rk[1]), .key2(rk[2]), .key3(rk[3]), .key4(rk[4]),
      .key5(rk[5]), .key6(rk[6]), .key7(rk[7]), .key8(rk[8]), .key9(rk[9]),
      .key10(rk[10]), .out(out), .out_valid(out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from first principles: multiplicative inverse followed by the affine map.
   task automatic build_sbox;
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_m[x] = s;
      end
   endtask

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]};
            t = t ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] aes_model(input logic [127:0] pt);
      logic [7:0]   s [0:15];
      logic [7:0]   t [0:15];
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
      for (int round = 1; round <= 10; round++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
         for (int i = 0; i < 16; i++) s[i] = t[i];
         if (round < 10) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  s[r+4*c] = gmul(8'h02, t[r+4*c]) ^ gmul(8'h03, t[(r+1)%4+4*c])
                             ^ t[(r+2)%4+4*c] ^ t[(r+3)%4+4*c];
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[round][127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic encrypt(input logic [127:0] pt, output logic [127:0] ct,
                          output int latency, output int low_cycles);
      latency = -1; ct = '0; low_cycles = 0;
      pt_in = pt; start = 1'b1;
      step();
      start = 1'b0;
      if (!in_ready) low_cycles++;
      for (int t = 1; t <= 40; t++) begin
         step();
         if (out_valid) begin
            ct = out; latency = t; valid_count++;
            break;
         end
         if (!in_ready) low_cycles++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; pt_in = '0;
      step(); step();
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 128'h0) begin
         tests_failed++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h, required 1 0 0", in_ready, out_valid, out);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_fips(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] exp_ct);
      logic [127:0] ct;
      int lat, low;
      expand_key(key);
      encrypt(pt, ct, lat, low);
      tests_run++;
      if (ct !== exp_ct) begin
         tests_failed++;
         $display("FAIL fips_ct: got %h required %h", ct, exp_ct);
      end
      tests_run++;
      if (lat !== 10) begin
         tests_failed++;
         $display("FAIL fips_latency: got %0d required 10", lat);
      end
      tests_run++;
      if (low !== 10) begin
         tests_failed++;
         $display("FAIL fips_busy_cycles: got %0d required 10", low);
      end
      step();
   endtask

   task automatic test_back_to_back;
      int idx, last, low, pulse_len;
      logic [127:0] exp_ct;
      idx = 0; last = 0; low = 0; pulse_len = 0;
      expand_key(C1_KEY); pt_in = C1_PT; start = 1'b1;
      step();
      if (!in_ready) low++;
      for (int t = 1; t <= 80 && idx < 4; t++) begin
         step();
         if (out_valid) begin
            exp_ct = (idx % 2 == 0) ? C1_CT : B_CT;
            tests_run++;
            if (out !== exp_ct) begin
               tests_failed++;
               $display("FAIL b2b_ct[%0d]: got %h required %h", idx, out, exp_ct);
            end
            tests_run++;
            if (t - last !== ((idx == 0) ? 10 : 11)) begin
               tests_failed++;
               $display("FAIL b2b_spacing[%0d]: got %0d required %0d", idx, t - last, (idx == 0) ? 10 : 11);
            end
            tests_run++;
            if (low !== 10) begin
               tests_failed++;
               $display("FAIL b2b_busy[%0d]: got %0d required 10", idx, low);
            end
            last = t; low = 0; idx++;
            if (idx < 4) begin
               if (idx % 2 == 0) begin expand_key(C1_KEY); pt_in = C1_PT; end
               else begin expand_key(B_KEY); pt_in = B_PT; end
            end else begin
               start = 1'b0;
            end
         end else if (!in_ready) begin
            low++;
         end
         if (out_valid) pulse_len++;
      end
      start = 1'b0;
      tests_run++;
      if (idx !== 4 || pulse_len !== 4) begin
         tests_failed++;
         $display("FAIL b2b_completions: got %0d blocks %0d pulses required 4 4", idx, pulse_len);
      end
      step(); step();
   endtask

   task automatic test_start_during_run;
      logic [127:0] other, got;
      int seen;
      seen = -1; got = '0;
      other = {$urandom, $urandom, $urandom, $urandom};
      expand_key(C1_KEY); pt_in = C1_PT; start = 1'b1;
      step();
      for (int t = 1; t <= 30; t++) begin
         if (t == 3 || t == 7) begin start = 1'b1; pt_in = other; end
         else start = 1'b0;
         step();
         if (out_valid) begin seen = t; got = out; break; end
      end
      start = 1'b0;
      tests_run++;
      if (got !== C1_CT) begin
         tests_failed++;
         $display("FAIL ignore_start_ct: got %h required %h", got, C1_CT);
      end
      tests_run++;
      if (seen !== 10) begin
         tests_failed++;
         $display("FAIL ignore_start_latency: got %0d required 10", seen);
      end
      step();
   endtask

   task automatic test_reset_midop;
      logic [127:0] ct;
      int lat, low, spurious;
      spurious = 0;
      expand_key(C1_KEY); pt_in = C1_PT; start = 1'b1;
      step();
      start = 1'b0;
      for (int t = 1; t <= 4; t++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || out !== 128'h0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_state: out_valid=%b out=%h in_ready=%b, required 0 0 1", out_valid, out, in_ready);
      end
      for (int t = 0; t < 12; t++) begin
         step();
         if (out_valid) spurious++;
      end
      tests_run++;
      if (spurious !== 0) begin
         tests_failed++;
         $display("FAIL abort_no_valid: got %0d pulses required 0", spurious);
      end
      encrypt(C1_PT, ct, lat, low);
      tests_run++;
      if (ct !== C1_CT || lat !== 10) begin
         tests_failed++;
         $display("FAIL abort_recover: got %h lat %0d required %h lat 10", ct, lat, C1_CT);
      end
      step();
   endtask

   task automatic test_random;
      logic [127:0] key, pt, ct, exp_ct;
      int lat, low;
      valid_count = 0; accept_count = 0;
      for (int n = 0; n < 1000; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         expand_key(key);
         exp_ct = aes_model(pt);
         if (in_ready) accept_count++;
         encrypt(pt, ct, lat, low);
         tests_run++;
         if (ct !== exp_ct || lat !== 10) begin
            tests_failed++;
            $display("FAIL random[%0d]: got %h lat %0d required %h lat 10", n, ct, lat, exp_ct);
         end
         if ($urandom_range(1, 0) == 1) step();
      end
      step();
      tests_run++;
      if (valid_count !== accept_count) begin
         tests_failed++;
         $display("FAIL random_valid_count: got %0d required %0d", valid_count, accept_count);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      tests_run = 0; tests_failed = 0; valid_count = 0; accept_count = 0;
      rst = 1'b1; start = 1'b0; pt_in = '0;
      for (int i = 0; i < 11; i++) rk[i] = '0;
      build_sbox();
      test_reset();
      test_fips(C1_KEY, C1_PT, C1_CT);
      test_fips(B_KEY, B_PT, B_CT);
      test_back_to_back();
      test_start_during_run();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
